// File: rtl/mmio_responder.sv
// Memory-mapped responder: GPIO, loadable timer, TX byte FIFO and status in a
// 16-byte window. Reads are registered so data lines up with the M stage.
module mmio_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_8000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr_x,
  input  logic [31:0] wdata_x,
  input  logic        we_x,
  input  logic        re_x,
  output logic [31:0] rdata_m,
  output logic        hit_m,
  output logic [31:0] gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          hit;
  logic [1:0]    sel;
  logic          wrGpio, wrTimer, wrTx, wrStatus;
  logic          pop, pushOk, full, empty;
  logic [31:0]   timer, readMux, status;
  logic [PW-1:0] rdPtr, wrPtr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    mem [FIFO_DEPTH];

  assign hit      = (addr_x[31:4] == BASE_ADDR[31:4]);
  assign sel      = addr_x[3:2];
  assign wrGpio   = we_x && hit && (sel == 2'd0);
  assign wrTimer  = we_x && hit && (sel == 2'd1);
  assign wrTx     = we_x && hit && (sel == 2'd2);
  assign wrStatus = we_x && hit && (sel == 2'd3);

  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign tx_valid = !empty;
  assign tx_data  = mem[rdPtr];
  assign pop      = tx_valid && tx_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign pushOk   = wrTx && (!full || pop);

  assign status = {24'b0, 5'(count), overflow, full, empty};

  always_comb begin
    readMux = '0;
    case (sel)
      2'd0:    readMux = gpio_out;
      2'd1:    readMux = timer;
      2'd3:    readMux = status;
      default: readMux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out <= '0;
      timer    <= '0;
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rdata_m  <= '0;
      hit_m    <= 1'b0;
    end else begin
      if (wrGpio) gpio_out <= wdata_x;
      timer <= wrTimer ? wdata_x : timer + 32'd1;
      if (pushOk) wrPtr <= wrPtr + PW'(1);
      if (pop)    rdPtr <= rdPtr + PW'(1);
      count <= count + CW'(pushOk) - CW'(pop);
      if (wrTx && !pushOk)              overflow <= 1'b1;
      else if (wrStatus && wdata_x[2])  overflow <= 1'b0;
      // Reads sample pre-edge state, so a same-cycle write is not visible yet.
      rdata_m <= (re_x && hit) ? readMux : '0;
      hit_m   <= re_x && hit;
    end
  end

  // Storage needs no reset; pointers and count define its validity.
  always_ff @(posedge clk) begin
    if (!reset && pushOk) mem[wrPtr] <= wdata_x[7:0];
  end
endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: register access, timer wrap, FIFO
// fill/overflow/drain, push-with-pop on full, and mid-stream reset.
module tb_mmio_responder;
  localparam logic [31:0] BASE = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr_x, wdata_x;
  logic        we_x, re_x, tx_ready;
  logic [31:0] rdata_m, gpio_out;
  logic        hit_m, tx_valid;
  logic [7:0]  tx_data;
  int          checks = 0;
  int          errs = 0;

  mmio_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .addr_x(addr_x), .wdata_x(wdata_x),
    .we_x(we_x), .re_x(re_x), .rdata_m(rdata_m), .hit_m(hit_m),
    .gpio_out(gpio_out), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setIn(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    we_x = w; re_x = r; addr_x = a; wdata_x = d;
  endtask

  initial begin
    reset = 1'b1; tx_ready = 1'b0;
    setIn(0, 0, 32'h0, 32'h0);
    step(); step();
    reset = 1'b0;
    chk("rst_gpio", gpio_out, 32'h0);
    chk("rst_txvalid", {31'b0, tx_valid}, 32'h0);
    chk("rst_rdata", rdata_m, 32'h0);
    chk("rst_hit", {31'b0, hit_m}, 32'h0);

    setIn(0, 1, BASE, 0); step();
    chk("rd_gpio0", rdata_m, 32'h0);
    chk("rd_gpio0_hit", {31'b0, hit_m}, 32'h1);
    setIn(0, 1, BASE + 32'hC, 0); step();
    chk("rd_status0", rdata_m, 32'h01);

    setIn(1, 0, BASE, 32'hDEAD_BEEF); step();
    chk("wr_gpio", gpio_out, 32'hDEAD_BEEF);
    chk("rd_idle_zero", rdata_m, 32'h0);
    setIn(0, 1, BASE + 32'h3, 0); step();
    chk("rd_gpio", rdata_m, 32'hDEAD_BEEF);
    setIn(1, 1, 32'h0000_0040, 32'h1234_5678); step();
    chk("miss_gpio", gpio_out, 32'hDEAD_BEEF);
    chk("miss_hit", {31'b0, hit_m}, 32'h0);
    chk("miss_rdata", rdata_m, 32'h0);

    // Simultaneous write+read returns the old value
    setIn(1, 1, BASE, 32'hCAFE_0000); step();
    chk("wr_rd_old", rdata_m, 32'hDEAD_BEEF);
    chk("wr_rd_new", gpio_out, 32'hCAFE_0000);

    setIn(1, 0, BASE + 32'h4, 32'hFFFF_FFFE); step();
    setIn(0, 0, 0, 0); step();
    setIn(0, 1, BASE + 32'h4, 0); step();
    chk("timer_ff", rdata_m, 32'hFFFF_FFFF);
    step();
    chk("timer_wrap", rdata_m, 32'h0);

    setIn(0, 1, BASE + 32'h8, 0); step();
    chk("rd_txdata", rdata_m, 32'h0);
    chk("rd_txdata_hit", {31'b0, hit_m}, 32'h1);

    for (int i = 0; i < 5; i++) begin
      setIn(1, 0, BASE + 32'h8, 32'h0000_0041 + i); step();
    end
    chk("fill_valid", {31'b0, tx_valid}, 32'h1);
    chk("fill_head", {24'b0, tx_data}, 32'h41);
    setIn(0, 1, BASE + 32'hC, 0); step();
    chk("status_ovf", rdata_m, 32'h26);

    setIn(0, 0, 0, 0); tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", {31'b0, tx_valid}, 32'h1);
      chk("drain_data", {24'b0, tx_data}, 32'h41 + i);
      step();
    end
    chk("drain_empty", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    setIn(1, 0, BASE + 32'hC, 32'h4); step();
    setIn(0, 1, BASE + 32'hC, 0); step();
    chk("ovf_clear", rdata_m, 32'h01);

    for (int i = 0; i < 4; i++) begin
      setIn(1, 0, BASE + 32'h8, 32'h0000_0051 + i); step();
    end
    tx_ready = 1'b1;
    setIn(1, 0, BASE + 32'h8, 32'h99); step();
    tx_ready = 1'b0;
    setIn(0, 1, BASE + 32'hC, 0); step();
    chk("pushpop_status", rdata_m, 32'h22);
    setIn(0, 0, 0, 0); tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pp_data", {24'b0, tx_data}, (i < 3) ? 32'h52 + i : 32'h99);
      step();
    end
    chk("pp_empty", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      setIn(1, 0, BASE + 32'h8, 32'h0000_0061 + i); step();
    end
    setIn(1, 0, BASE, 32'h55); step();
    chk("pre_rst_gpio", gpio_out, 32'h55);
    reset = 1'b1;
    setIn(1, 0, BASE + 32'h8, 32'h64); step();
    reset = 1'b0;
    setIn(0, 0, 0, 0);
    chk("midrst_valid", {31'b0, tx_valid}, 32'h0);
    chk("midrst_gpio", gpio_out, 32'h0);
    setIn(0, 1, BASE + 32'hC, 0); step();
    chk("midrst_status", rdata_m, 32'h01);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
